// File: rtl/stream_unaligner.sv
// stream_unaligner: byte-aligned sliding window over a densely packed input stream
// Ports:
//   clk, reset (sync, active-low)
//   in_valid/in_ready/in_data/in_tkeep/in_tlast : packed AXI-Stream style input
//   win_data/win_valid/win_bytes/win_last       : oldest unconsumed bytes, LSB first
//   consume_en/consume_len                      : decoder retires bytes from the window
//   err                                         : sticky protocol error
// Optional checking: define UNALIGNER_CHECK_EN to enable err; otherwise err is tied low.
module stream_unaligner #(
    parameter int DATA_IN_WIDTH = 256,
    parameter int WINDOW_WIDTH  = 272,
    parameter int LEN_WIDTH     = 8,
    parameter int BUF_WIDTH     = 768
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_IN_WIDTH-1:0]   in_data,
    input  logic [DATA_IN_WIDTH/8-1:0] in_tkeep,
    input  logic                       in_tlast,
    output logic [WINDOW_WIDTH-1:0]    win_data,
    output logic                       win_valid,
    output logic [6:0]                 win_bytes,
    output logic                       win_last,
    input  logic                       consume_en,
    input  logic [LEN_WIDTH-1:0]       consume_len,
    output logic                       err
);
    localparam int IN_BYTES  = DATA_IN_WIDTH / 8;
    localparam int WIN_B     = WINDOW_WIDTH / 8;
    localparam int BUF_BYTES = BUF_WIDTH / 8;
    localparam int OW        = $clog2(BUF_BYTES + 1);
    localparam int KW        = $clog2(IN_BYTES + 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                     state, state_next;
    logic [BUF_WIDTH-1:0]       data_buf, buf_next;
    logic [OW-1:0]              occ, occ_next, c, rem;
    logic [KW-1:0]              k;
    logic [DATA_IN_WIDTH-1:0]   masked;
    logic                       keep_run, run_q, accept, take;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == DRAIN) state_next = (occ == '0) ? IDLE : DRAIN;
        else if (accept)    state_next = in_tlast ? DRAIN : FILL;
    end

    // run_q keeps in_ready low until the first edge after reset release
    always_comb begin
        in_ready  = reset & run_q & (state != DRAIN) & (occ <= OW'(BUF_BYTES - IN_BYTES));
        win_valid = (occ >= OW'(WIN_B)) | ((state == DRAIN) & (occ != '0));
        win_last  = state == DRAIN;
        win_bytes = (occ >= OW'(WIN_B)) ? 7'(WIN_B) : 7'(occ);
        win_data  = data_buf[WINDOW_WIDTH-1:0];
    end

    // Only the lowest contiguous run of tkeep counts; bytes past it are zeroed
    // so the buffer stays clean above occ.
    always_comb begin
        k        = '0;
        keep_run = 1'b1;
        masked   = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            keep_run          = keep_run & in_tkeep[i];
            k                 = k + KW'(keep_run);
            masked[i*8 +: 8]  = keep_run ? in_data[i*8 +: 8] : 8'h00;
        end
        accept   = in_valid & in_ready;
        take     = consume_en & win_valid;
        c        = !take ? '0 : (consume_len > LEN_WIDTH'(occ)) ? occ : consume_len[OW-1:0];
        rem      = occ - c;
        occ_next = rem + (accept ? OW'(k) : '0);
        buf_next = (data_buf >> {c, 3'b000}) |
                   (accept ? (BUF_WIDTH'(masked) << {rem, 3'b000}) : '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ      <= '0;
            data_buf <= '0;
            run_q    <= 1'b0;
        end else begin
            occ      <= occ_next;
            data_buf <= buf_next;
            run_q    <= 1'b1;
        end
    end

`ifdef UNALIGNER_CHECK_EN
    logic viol;

    always_comb begin
        viol = (consume_en & ((LEN_WIDTH'(win_bytes) < consume_len) | (consume_len == '0) | !win_valid)) |
               (accept & ((in_tkeep >> k) != '0));
    end

    always_ff @(posedge clk) begin
        if (!reset)    err <= 1'b0;
        else if (viol) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
